// File: rtl/thz_frame_pkg.sv
// Shared types and constants for the THz frame-store readout path.
// Used by the sequencer RTL and by benches building golden models.
package thz_frame_pkg;

  localparam int NUM_FRAMES    = 30;
  localparam int PIX_PER_FRAME = 8;
  localparam int TIMEOUT       = 16;
  localparam int FIFO_DEPTH    = 2;

  localparam int PIX_W   = 10;
  localparam int ADDR_W  = 4;
  localparam int FRAME_W = 5;
  localparam int IDX_W   = 3;
  localparam int TMO_W   = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [PIX_W-1:0]  pixel;
    logic [ADDR_W-1:0] addr;
  } pixel_entry_t;

  typedef struct packed {
    pixel_entry_t     entry;
    logic [IDX_W-1:0] idx;
    logic             sof;
    logic             eof;
  } readout_word_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_BAD_FRAME = 2'b01,
    ERR_TIMEOUT   = 2'b10
  } err_code_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } seq_state_e;

endpackage

// File: rtl/frame_readout_seq_fifo.sv
// Small synchronous FIFO of readout words between the store side and the
// output stream; flush discards contents without touching storage.
module readout_fifo
  import thz_frame_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  readout_word_t push_word,
  input  logic          pop,
  input  logic          flush,
  output readout_word_t head,
  output logic          full,
  output logic          empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  readout_word_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_push = push && (!full || do_pop);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count defines validity and the
  // top gates every head field with m_valid, so stale entries never escape.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/frame_readout_seq.sv
// Reader-side sequencer: walks one frame of the store, buffers each entry
// and streams it out with start/end-of-frame markers.
module frame_readout_seq
  import thz_frame_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] start_frame,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic               ram_read_en,
  output logic [FRAME_W-1:0] ram_frame_read_sel,
  output logic [IDX_W-1:0]   ram_pixel_index_out,
  input  logic [PIX_W-1:0]   ram_pixel_data_in,
  input  logic [ADDR_W-1:0]  ram_pixel_addr_in,
  input  logic               ram_valid_in,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [PIX_W-1:0]   m_pixel,
  output logic [ADDR_W-1:0]  m_addr,
  output logic [IDX_W-1:0]   m_index,
  output logic               m_sof,
  output logic               m_eof
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIX_PER_FRAME - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

  seq_state_e         state, state_next;
  logic [FRAME_W-1:0] frame_q, frame_next;
  logic [IDX_W-1:0]   idx_q, idx_next;
  logic [TMO_W-1:0]   tmo_q, tmo_next;
  logic               busy_q, busy_next;
  logic               done_q, done_next;
  logic               err_q, err_next;
  err_code_e          err_code_q, err_code_next;

  logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  readout_word_t push_word, head;

  always_comb begin
    push_word.entry.pixel = ram_pixel_data_in;
    push_word.entry.addr  = ram_pixel_addr_in;
    push_word.idx         = idx_q;
    push_word.sof         = (idx_q == '0);
    push_word.eof         = (idx_q == IDX_LAST);
  end

  readout_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_word (push_word),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m_valid  = !fifo_empty;
  assign fifo_pop = m_valid && m_ready;

  // NOTE: non-blocking assignments only, so every register samples the
  // pre-edge values computed by the combinational block below.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      frame_q    <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state      <= state_next;
      frame_q    <= frame_next;
      idx_q      <= idx_next;
      tmo_q      <= tmo_next;
      busy_q     <= busy_next;
      done_q     <= done_next;
      err_q      <= err_next;
      err_code_q <= err_code_next;
    end
  end

  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_next    = state;
    frame_next    = frame_q;
    idx_next      = idx_q;
    tmo_next      = tmo_q;
    busy_next     = busy_q;
    done_next     = 1'b0;
    err_next      = 1'b0;
    err_code_next = err_code_q;
    ram_read_en   = 1'b0;
    fifo_push     = 1'b0;
    fifo_flush    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (start_frame < FRAME_W'(NUM_FRAMES)) begin
            frame_next    = start_frame;
            idx_next      = '0;
            busy_next     = 1'b1;
            err_code_next = ERR_NONE;
            state_next    = S_ISSUE;
          end else begin
            err_next      = 1'b1;
            err_code_next = ERR_BAD_FRAME;
          end
        end
      end
      S_ISSUE: begin
        // Holding here while full is what backpressures the store.
        if (!fifo_full) begin
          ram_read_en = 1'b1;
          tmo_next    = '0;
          state_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ram_valid_in) begin
          fifo_push = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_next = S_DRAIN;
          end else begin
            idx_next   = idx_q + 1'b1;
            state_next = S_ISSUE;
          end
        end else begin
          tmo_next = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
          if (tmo_next == TMO_MAX) begin
            err_next      = 1'b1;
            err_code_next = ERR_TIMEOUT;
            fifo_flush    = 1'b1;
            busy_next     = 1'b0;
            state_next    = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        // The eof word is the last one buffered, so its pop empties the FIFO.
        if (fifo_pop && head.eof) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign err                 = err_q;
  assign err_code            = err_code_q;
  assign ram_frame_read_sel  = frame_q;
  assign ram_pixel_index_out = idx_q;

  assign m_pixel = m_valid ? head.entry.pixel : '0;
  assign m_addr  = m_valid ? head.entry.addr  : '0;
  assign m_index = m_valid ? head.idx         : '0;
  assign m_sof   = m_valid && head.sof;
  assign m_eof   = m_valid && head.eof;

endmodule

// File: doc/frame_readout_seq.md
Name: frame_readout_seq

Overview:
- Reader-side sequencer for the ram4x4 frame store (30 frames x 8 pixels, each entry holding a 10-bit pixel and a 4-bit address tag).
- On a start request, it walks one frame's 8 entries in order: issues single-cycle read requests, waits for the store's valid response, and captures data and address.
- Streams each captured entry out on a ready/valid interface with start-of-frame and end-of-frame markers.
- Sits between the frame store and downstream THz image processing / host readout.

Parameters:
- NUM_FRAMES, 30, number of valid frames; a start_frame at or above this value is rejected.
- PIX_PER_FRAME, 8, entries per frame; the index counter wraps at this value.
- TIMEOUT, 16, maximum cycles to wait for ram_valid_in after a read request.
- FIFO_DEPTH, 2, output buffer depth in entries.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  start request; sampled only when busy=0.
- start_frame  in  5  frame number to read out.
- busy  out  1  high from an accepted start until done or err.
- done  out  1  one-cycle pulse after the last entry is accepted downstream.
- err  out  1  one-cycle pulse on an error.
- err_code  out  2  01=bad frame, 10=timeout; holds until the next start.
- ram_read_en  out  1  read strobe to the store; single-cycle pulse.
- ram_frame_read_sel  out  5  frame being read.
- ram_pixel_index_out  out  3  entry index being read.
- ram_pixel_data_in  in  10  pixel data returned by the store.
- ram_pixel_addr_in  in  4  address tag returned by the store.
- ram_valid_in  in  1  store response valid.
- m_valid  out  1  output stream valid.
- m_ready  in  1  downstream ready.
- m_pixel  out  10  output pixel.
- m_addr  out  4  output address tag.
- m_index  out  3  entry index of the output word.
- m_sof  out  1  marks entry 0 of the frame.
- m_eof  out  1  marks entry PIX_PER_FRAME-1 of the frame.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, the FIFO is empty, and the counters are 0. Reset mid-frame aborts immediately and drops any FIFO contents. No done or err pulse is produced by reset.
- IDLE:
  - start=1 with start_frame < NUM_FRAMES: latch the frame, set idx=0, busy=1, clear err_code, go to ISSUE.
  - start=1 with start_frame >= NUM_FRAMES: pulse err, set err_code=01, stay in IDLE, busy stays 0.
- ISSUE:
  - If the FIFO has a free slot, drive ram_read_en=1 for exactly one cycle with ram_frame_read_sel=frame and ram_pixel_index_out=idx, clear the timeout counter, go to WAIT.
  - If the FIFO is full, hold with ram_read_en=0; this backpressures the store.
- WAIT:
  - ram_valid_in=1: capture {ram_pixel_data_in, ram_pixel_addr_in, idx, sof=(idx==0), eof=(idx==PIX_PER_FRAME-1)} and push it into the FIFO in the same edge.
  - After the push: if idx is the last entry, go to DRAIN; otherwise idx++ and go to ISSUE.
  - A valid response arriving in the same cycle as the read request is not accepted; at least one cycle of latency is required.
  - The timeout counter increments each WAIT cycle. When it reaches TIMEOUT without a response: pulse err, set err_code=10, flush the FIFO, busy=0, go to IDLE.
- DRAIN: wait for the FIFO to empty, then pulse done, set busy=0, go to IDLE. done coincides with the cycle after the m_eof beat is accepted.
- Output stream:
  - m_valid = FIFO not empty; the head entry drives m_pixel, m_addr, m_index, m_sof and m_eof.
  - A pop occurs on m_valid & m_ready.
  - The head must hold stable while m_valid=1 and m_ready=0.
  - A simultaneous push and pop with the FIFO full is legal: the pop frees the slot and the count is unchanged.
- Stray responses: ram_valid_in outside WAIT is ignored, and no push occurs.
- start while busy=1 is ignored.
- Throughput with m_ready=1 and a 1-cycle store latency is 1 entry every 2 cycles (ISSUE + WAIT).
- Counters: idx is 3 bits and never wraps mid-frame. The timeout counter is clog2(TIMEOUT+1) bits wide and saturates.

Decomposition:
- Shared package thz_frame_pkg:
  - Constants NUM_FRAMES, PIX_PER_FRAME, PIX_W=10, ADDR_W=4, FRAME_W=5, IDX_W=3.
  - A packed typedef pixel_entry_t {pixel, addr}, also reused by benches for golden models.
  - A typedef readout_word_t {entry, idx, sof, eof}.
  - An enum for err_code.
- One sub-module, readout_fifo: synchronous FIFO of readout_word_t, FIFO_DEPTH deep, with push/pop/full/empty, using the same clk/rst.

Test Plan:
- Single frame, no backpressure: preload frame 3 entries with pixel=200+i, addr=i; start_frame=3; store latency 1, m_ready=1. Required: 8 beats in order with m_index 0..7, m_pixel 200..207, m_sof on beat 0 only, m_eof on beat 7 only, one done pulse, busy returning to 0.
- Bad frame: start_frame=30. Required: one-cycle err, err_code=01, no ram_read_en ever asserted, busy stays 0.
- Backpressure: m_ready=0 for 20 cycles after start on frame 0. Required: exactly 2 ram_read_en pulses and then the strobe is held at 0. Release m_ready: all 8 entries arrive intact, and the head stays stable during the stall.
- Timeout: store never asserts ram_valid_in after the read for entry 2. Required: err pulse with err_code=10 after exactly TIMEOUT=16 WAIT cycles, the FIFO flushed (m_valid=0), then return to IDLE. A following start on frame 1 completes normally.
- Reset mid-frame: assert rst after beat 4 is accepted. Required: next cycle all outputs are 0 with no done and no err. A restart on frame 29 streams all 8 entries of frame 29.
- Random: 30 frames with random data and addresses, random m_ready, store latency 1-3. Required: scoreboard match against a golden pixel_entry_t array, and exactly 30 done pulses.
